// File: rtl/logic_shift_unit_pkg.sv
// Shared types for the logic/shift unit: operation encoding and FSM states.
package logic_shift_unit_pkg;

   typedef enum logic [2:0] {
      OpAnd  = 3'b000,
      OpOr   = 3'b001,
      OpXor  = 3'b010,
      OpShr  = 3'b011,
      OpShl  = 3'b100,
      OpRotr = 3'b101,
      OpRotl = 3'b110,
      OpClr  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StShift = 2'b01,
      StDone  = 2'b10
   } lsu_state_e;

   function automatic logic is_shift(input op_e op);
      return (op == OpShr) || (op == OpShl) || (op == OpRotr) || (op == OpRotl);
   endfunction

endpackage

// File: rtl/logic_shift_unit_shift_step.sv
// One-bit shift/rotate step; bit_out is the bit that leaves the word.
module shift_step
   import logic_shift_unit_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] data,
   input  op_e          op,
   output logic [N-1:0] data_next,
   output logic         bit_out
);

   always_comb begin
      data_next = data;
      bit_out   = 1'b0;
      case (op)
         OpShr: begin
            data_next = {1'b0, data[N-1:1]};
            bit_out   = data[0];
         end
         OpShl: begin
            data_next = {data[N-2:0], 1'b0};
            bit_out   = data[N-1];
         end
         OpRotr: begin
            data_next = {data[0], data[N-1:1]};
            bit_out   = data[0];
         end
         OpRotl: begin
            data_next = {data[N-2:0], data[N-1]};
            bit_out   = data[N-1];
         end
         default: begin
            data_next = data;
            bit_out   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/logic_shift_unit.sv
// Handshaked logic/shift unit: bitwise ops finish in one edge, shifts step one bit per cycle.
module logic_shift_unit
   import logic_shift_unit_pkg::*;
#(
   parameter int unsigned N  = 8,
   localparam int unsigned SW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [2:0]   op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         zero,
   output logic         neg,
   output logic         carry
);

   lsu_state_e    r_state;
   lsu_state_e    w_state_next;
   logic [N-1:0]  r_work;
   logic [SW-1:0] r_cnt;
   op_e           r_op;
   logic [N-1:0]  r_result;
   logic          r_zero;
   logic          r_neg;
   logic          r_carry;

   op_e           w_op_in;
   logic [SW-1:0] w_amt;
   logic          w_accept;
   logic          w_start_shift;
   logic          w_load;
   logic [N-1:0]  w_load_val;
   logic          w_load_carry;
   logic [N-1:0]  w_step_data;
   logic          w_step_bit;

   assign w_op_in       = op_e'(op);
   assign w_amt         = B[SW-1:0];
   assign w_accept      = in_valid && (r_state == StIdle);
   assign w_start_shift = is_shift(w_op_in) && (w_amt != '0);

   shift_step #(
      .N (N)
   ) u_shift_step (
      .data      (r_work),
      .op        (r_op),
      .data_next (w_step_data),
      .bit_out   (w_step_bit)
   );

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_load_val   = r_result;
      w_load_carry = 1'b0;
      case (r_state)
         StIdle: begin
            if (in_valid) begin
               if (w_start_shift) begin
                  w_state_next = StShift;
               end else begin
                  w_state_next = StDone;
                  w_load       = 1'b1;
                  case (w_op_in)
                     OpAnd:   w_load_val = A & B;
                     OpOr:    w_load_val = A | B;
                     OpXor:   w_load_val = A ^ B;
                     OpClr:   w_load_val = '0;
                     default: w_load_val = A;  // shift/rotate by zero
                  endcase
               end
            end
         end
         StShift: begin
            // Final step: the shifted word goes straight into the output registers.
            if (r_cnt == SW'(1)) begin
               w_state_next = StDone;
               w_load       = 1'b1;
               w_load_val   = w_step_data;
               w_load_carry = w_step_bit;
            end
         end
         StDone: begin
            if (out_ready) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= StIdle;
         r_work   <= '0;
         r_cnt    <= '0;
         r_op     <= OpAnd;
         r_result <= '0;
         r_zero   <= 1'b1;
         r_neg    <= 1'b0;
         r_carry  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_work <= A;
            r_op   <= w_op_in;
            r_cnt  <= w_start_shift ? w_amt : '0;
         end else if (r_state == StShift) begin
            r_work <= w_step_data;
            r_cnt  <= r_cnt - SW'(1);
         end
         if (w_load) begin
            r_result <= w_load_val;
            r_zero   <= (w_load_val == '0);
            r_neg    <= w_load_val[N-1];
            r_carry  <= w_load_carry;
         end
      end
   end

   assign in_ready  = (r_state == StIdle);
   assign out_valid = (r_state == StDone);
   assign result    = r_result;
   assign zero      = r_zero;
   assign neg       = r_neg;
   assign carry     = r_carry;

endmodule

// File: tb/tb_logic_shift_unit.sv
// Self-checking bench for logic_shift_unit: directed vectors, corner sequences, random ops.
module tb_logic_shift_unit;

   localparam int N = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic [2:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] result;
   logic         zero;
   logic         neg;
   logic         carry;

   int checks = 0;
   int errors = 0;

   logic_shift_unit #(
      .N (N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .neg       (neg),
      .carry     (carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] o;
      logic [7:0] res;
      logic       z;
      logic       n;
      logic       c;
      int         lat;
   } vec_t;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference behaviour from the op definitions: whole-word shifts, latency in edges.
   function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                                 output logic [7:0] r, output logic c, output int lat);
      int k;
      k   = int'(b[2:0]);
      c   = 1'b0;
      lat = 1;
      r   = a;
      case (o)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = a ^ b;
         3'd7: r = 8'h00;
         default: begin
            if (k != 0) begin
               lat = k + 1;
               case (o)
                  3'd3: begin r = a >> k; c = a[k-1]; end
                  3'd4: begin r = a << k; c = a[N-k]; end
                  3'd5: begin r = (a >> k) | (a << (N - k)); c = a[k-1]; end
                  default: begin r = (a << k) | (a >> (N - k)); c = a[N-k]; end
               endcase
            end
         end
      endcase
   endfunction

   // Issue one op and wait for out_valid; leaves the result parked in DONE.
   task automatic do_op(input vec_t v, input string tag);
      int lat;
      @(negedge clk);
      chk({tag, ".in_ready_idle"}, int'(in_ready), 1);
      in_valid = 1'b1;
      A        = v.a;
      B        = v.b;
      op       = v.o;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A        = 8'($urandom);
      B        = 8'($urandom);
      op       = 3'($urandom);
      lat      = 1;
      while (!out_valid && lat < 3 * N) begin
         chk({tag, ".in_ready_busy"}, int'(in_ready), 0);
         @(posedge clk);
         #1;
         A  = 8'($urandom);
         op = 3'($urandom);
         lat++;
      end
      chk({tag, ".latency"}, lat, v.lat);
      chk({tag, ".out_valid"}, int'(out_valid), 1);
      chk({tag, ".result"}, int'(result), int'(v.res));
      chk({tag, ".zero"}, int'(zero), int'(v.z));
      chk({tag, ".neg"}, int'(neg), int'(v.n));
      chk({tag, ".carry"}, int'(carry), int'(v.c));
   endtask

   task automatic release_out(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, ".out_valid_after"}, int'(out_valid), 0);
      chk({tag, ".in_ready_after"}, int'(in_ready), 1);
   endtask

   vec_t vecs[8];
   vec_t v;

   initial begin
      vecs[0] = '{a: 8'hF0, b: 8'h3C, o: 3'd0, res: 8'h30, z: 0, n: 0, c: 0, lat: 1};
      vecs[1] = '{a: 8'h81, b: 8'h03, o: 3'd4, res: 8'h08, z: 0, n: 0, c: 0, lat: 4};
      vecs[2] = '{a: 8'h01, b: 8'h01, o: 3'd5, res: 8'h80, z: 0, n: 1, c: 1, lat: 2};
      vecs[3] = '{a: 8'h5A, b: 8'h5A, o: 3'd2, res: 8'h00, z: 1, n: 0, c: 0, lat: 1};
      vecs[4] = '{a: 8'hA5, b: 8'h08, o: 3'd6, res: 8'hA5, z: 0, n: 1, c: 0, lat: 1};
      vecs[5] = '{a: 8'hFF, b: 8'hFF, o: 3'd7, res: 8'h00, z: 1, n: 0, c: 0, lat: 1};
      vecs[6] = '{a: 8'hFF, b: 8'h07, o: 3'd3, res: 8'h01, z: 0, n: 0, c: 1, lat: 8};
      vecs[7] = '{a: 8'h12, b: 8'h80, o: 3'd1, res: 8'h92, z: 0, n: 1, c: 0, lat: 1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = '0;
      B         = '0;
      op        = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.in_ready", int'(in_ready), 1);
      chk("reset.out_valid", int'(out_valid), 0);
      chk("reset.result", int'(result), 0);
      chk("reset.zero", int'(zero), 1);
      chk("reset.neg", int'(neg), 0);
      chk("reset.carry", int'(carry), 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table
      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i], $sformatf("vec%0d", i));
         release_out($sformatf("vec%0d", i));
      end

      // Backpressure: hold the result in DONE for five cycles
      v = '{a: 8'h0F, b: 8'h02, o: 3'd6, res: 8'h3C, z: 0, n: 0, c: 0, lat: 3};
      do_op(v, "bp");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp.out_valid_hold", int'(out_valid), 1);
         chk("bp.in_ready_hold", int'(in_ready), 0);
         chk("bp.result_hold", int'(result), 8'h3C);
         chk("bp.flags_hold", int'({zero, neg, carry}), 0);
      end
      release_out("bp");

      // Reset in the middle of a shift aborts it
      @(negedge clk);
      in_valid = 1'b1;
      A        = 8'hFF;
      B        = 8'h07;
      op       = 3'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid.out_valid", int'(out_valid), 0);
      chk("rst_mid.result", int'(result), 0);
      chk("rst_mid.zero", int'(zero), 1);
      chk("rst_mid.in_ready", int'(in_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      do_op(vecs[0], "after_rst");
      release_out("after_rst");

      // Random ops against the model
      for (int i = 0; i < 150; i++) begin
         v.a = 8'($urandom);
         v.b = 8'($urandom);
         v.o = 3'($urandom_range(0, 7));
         model(v.a, v.b, v.o, v.res, v.c, v.lat);
         v.z = (v.res == 8'h00);
         v.n = v.res[7];
         do_op(v, $sformatf("rnd%0d", i));
         release_out($sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/logic_shift_unit.md
LOGIC_SHIFT_UNIT -- requirements
Module: logic_shift_unit

Interface
REQ-001 SHALL have parameter N, default 8: operand/result width; power of two, N >= 4.
REQ-002 SHALL have localparam SW = $clog2(N): shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands and op presented.
REQ-006 SHALL have port in_ready  output  1  unit accepts a new operation.
REQ-007 SHALL have port A  input  N  first operand, also the shift/rotate source.
REQ-008 SHALL have port B  input  N  second operand; B[SW-1:0] is the shift/rotate amount.
REQ-009 SHALL have port op  input  3  000 AND, 001 OR, 010 XOR, 011 SHR, 100 SHL, 101 ROTR, 110 ROTL, 111 CLR.
REQ-010 SHALL have port out_valid  output  1  result and flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port result  output  N  registered result.
REQ-013 SHALL have port zero  output  1  result == 0.
REQ-014 SHALL have port neg  output  1  result[N-1].
REQ-015 SHALL have port carry  output  1  last bit shifted or rotated out; 0 for non-shift ops and for amount 0.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE.
REQ-018 SHALL accept an operation on the edge where in_valid && in_ready, capturing A, B[SW-1:0] and op.
REQ-019 On accepting AND/OR/XOR/CLR, SHALL load result (CLR gives all zeros) and flags, and go IDLE->DONE; out_valid rises 1 edge after acceptance.
REQ-020 On accepting a shift/rotate with amount 0, SHALL load result = A with carry 0, and go IDLE->DONE.
REQ-021 On accepting a shift/rotate with amount k > 0, SHALL load a work register with A and a counter with k, and go IDLE->SHIFT.
REQ-022 In SHIFT, SHALL perform one 1-bit step per cycle and decrement the counter, recording the bit moved out as carry.
REQ-023 Step rules: SHR and SHL shift in 0; ROTR moves bit0 to the MSB; ROTL moves the MSB to bit0.
REQ-024 When the counter reaches 0, SHALL go SHIFT->DONE with result, zero, neg and carry updated; out_valid rises exactly k+1 edges after acceptance.
REQ-025 In DONE, SHALL assert out_valid and hold result and flags stable until out_valid && out_ready, then go DONE->IDLE.
REQ-026 SHALL NOT accept a new operation in the same cycle as the output handshake; a back-to-back issue costs one IDLE cycle.
REQ-027 SHALL drive out_valid = 0 in IDLE and SHIFT; result and flags keep their last values outside DONE.
REQ-028 SHALL ignore A, B and op changes while in SHIFT or DONE.
REQ-029 SHALL keep the maximum latency at N edges (amount N-1).

Reset
REQ-030 While rst is high, SHALL be in IDLE with in_ready = 1, out_valid = 0, result = 0, zero = 1, neg = 0, carry = 0, counter = 0.
REQ-031 Reset asserted mid-SHIFT or in DONE SHALL abort immediately; the in-flight operation is lost with no output handshake.
REQ-032 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-033 A shared package SHALL hold the op encoding enum (op_e) and the FSM state enum (lsu_state_e).
REQ-034 The 1-bit step logic SHALL be a combinational sub-module, shift_step #(N), with inputs data and op and outputs data_next and bit_out.
REQ-035 The FSM, counter, operand registers and output registers SHALL stay in logic_shift_unit.

Verification (N=8)
REQ-036 AND: A=0xF0, B=0x3C -> result 0x30, zero 0, neg 0, carry 0, out_valid 1 edge after acceptance.
REQ-037 SHL: A=0x81, B=3 -> result 0x08, carry 0, out_valid 4 edges after acceptance, in_ready 0 throughout.
REQ-038 ROTR: A=0x01, B=1 -> result 0x80, neg 1, carry 1; XOR A=B=0x5A -> result 0x00, zero 1.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles in DONE -> result and flags stable, in_ready 0; out_ready=1 -> IDLE next edge.
REQ-040 Reset mid-SHIFT: SHR A=0xFF, B=7, rst pulsed at cycle 3 -> out_valid 0, result 0x00, zero 1, in_ready 1; a new AND completes correctly.
REQ-041 Boundaries: amount 0 (ROTL A=0xA5, B=0x08 -> 0xA5, carry 0) and CLR (-> 0x00, zero 1).
